// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, shifts one
// byte out on device clock edges, then checks the device acknowledge and bus release.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

    state_t        state, state_d;
    logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic          fall;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic          drive_q, drive_d;
    logic [3:0]    edge_q, edge_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] to_q, to_d;
    logic          timed, timeout;
    logic          done_d, error_d;

    // NOTE: the synchronizer resets to the idle-high line level, so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state    <= IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            drive_q  <= 1'b0;
            edge_q   <= '0;
            inh_q    <= '0;
            to_q     <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            state    <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            drive_q  <= drive_d;
            edge_q   <= edge_d;
            inh_q    <= inh_d;
            to_q     <= to_d;
            tx_busy  <= (state_d != IDLE);
            tx_done  <= done_d;
            tx_error <= error_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
        state_d    = state;
        data_d     = data_q;
        parity_d   = parity_q;
        drive_d    = drive_q;
        edge_d     = edge_q;
        inh_d      = inh_q;
        to_d       = to_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;

        // Pulses are registered, so the terminal count sits one below the limit to land
        // tx_error exactly TIMEOUT_CYCLES after the RTS cycle.
        timed   = state inside {SEND, ACK, WAIT_IDLE};
        timeout = timed && (to_q == TW'(TIMEOUT_CYCLES - 2));
        if (timed) to_d = to_q + TW'(1);

        case (state)
            IDLE: begin
                inh_d = '0;
                if (tx_req) begin
                    data_d   = tx_data;
                    parity_d = ~^tx_data;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                inh_d      = inh_q + IW'(1);
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    ps2_dat_oe = 1'b1;
                    state_d    = RTS;
                end
            end
            RTS: begin
                ps2_dat_oe = 1'b1;
                edge_d     = '0;
                to_d       = '0;
                drive_d    = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                ps2_dat_oe = drive_q;
                if (fall) begin
                    edge_d = edge_q + 4'd1;
                    if (edge_q < 4'd8) begin
                        drive_d = ~data_q[edge_q[2:0]];
                    end else if (edge_q == 4'd8) begin
                        drive_d = ~parity_q;
                    end else begin
                        drive_d = 1'b0;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    if (!dat_s2) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout && !done_d && !error_d) begin
            error_d = 1'b1;
            state_d = IDLE;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks the byte out,
// samples the data line and optionally acknowledges.
module tb_ps2_host_tx;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_busy, tx_done, tx_error;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_done_cyc = -1;
    int last_inh_cyc = -1;
    bit both_seen = 1'b0;
    logic clk_oe_prev = 1'b0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .reset_in(reset_in),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .tx_data(tx_data), .tx_req(tx_req),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
        if (tx_error === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_seen = 1'b1;
        if (ps2_clk_oe === 1'b1 && clk_oe_prev !== 1'b1) last_inh_cyc = cyc;
        clk_oe_prev = ps2_clk_oe;
    end

    task automatic start_req(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req  = 1'b0;
    endtask

    // Device side: waits for request-to-send, clocks 11 edges, samples the line before each rise.
    task automatic dev_xfer(input bit ack, output logic [10:0] lb, output bit ok);
        int n = 0;
        lb = '0;
        ok = 1'b1;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1)) begin
            if (n == 6000) begin ok = 1'b0; return; end
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        lb[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            lb[k] = ps2_dat_in;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (ack) dev_dat = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wait_end(input int d0, input int e0);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) break;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b want=0", ps2_clk_oe); end
        total++; if (ps2_dat_oe !== 1'b0) begin bad++; $display("FAIL reset_dat_oe got=%b want=0", ps2_dat_oe); end
        total++; if ({tx_busy, tx_done, tx_error} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {tx_busy, tx_done, tx_error}); end
        reset_in = 1'b0;
        repeat (5) @(negedge clk);
        total++; if ({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error} !== 5'b0) begin bad++; $display("FAIL post_reset got=%b want=00000", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}); end
    endtask

    task automatic test_send_ed();
        logic [10:0] lb;
        bit ok;
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_req(8'hED);
        dev_xfer(1'b1, lb, ok);
        wait_end(d0, e0);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ed_rts got=%b want=1", ok); end
        total++; if (lb[0] !== 1'b0) begin bad++; $display("FAIL ed_start got=%b want=0", lb[0]); end
        total++; if (lb[8:1] !== 8'hED) begin bad++; $display("FAIL ed_data got=%h want=ed", lb[8:1]); end
        total++; if (lb[9] !== 1'b1) begin bad++; $display("FAIL ed_parity got=%b want=1", lb[9]); end
        total++; if (lb[10] !== 1'b1) begin bad++; $display("FAIL ed_stop got=%b want=1", lb[10]); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ed_done_count got=%0d want=1", done_cnt - d0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL ed_error_count got=%0d want=0", err_cnt - e0); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL ed_busy_after got=%b want=0", tx_busy); end
    endtask

    task automatic test_inhibit_f4();
        logic [10:0] lb;
        bit ok;
        int cnt = 0;
        int first = -1;
        int d0 = done_cnt;
        int e0 = err_cnt;
        @(negedge clk);
        tx_data = 8'hF4;
        tx_req  = 1'b1;
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL f4_busy_accept_cycle got=%b want=0", tx_busy); end
        @(negedge clk);
        tx_req = 1'b0;
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL f4_busy_next got=%b want=1", tx_busy); end
        while (ps2_clk_oe === 1'b1 && cnt < 6000) begin
            if (ps2_dat_oe === 1'b1 && first < 0) first = cnt;
            cnt++;
            @(negedge clk);
        end
        total++; if (cnt !== 5000) begin bad++; $display("FAIL f4_inhibit_len got=%0d want=5000", cnt); end
        total++; if (first !== 4999) begin bad++; $display("FAIL f4_dat_oe_rise got=%0d want=4999", first); end
        total++; if (ps2_dat_oe !== 1'b1) begin bad++; $display("FAIL f4_rts_dat got=%b want=1", ps2_dat_oe); end
        dev_xfer(1'b1, lb, ok);
        wait_end(d0, e0);
        total++; if (lb[8:1] !== 8'hF4) begin bad++; $display("FAIL f4_data got=%h want=f4", lb[8:1]); end
        total++; if (lb[9] !== 1'b0) begin bad++; $display("FAIL f4_parity got=%b want=0", lb[9]); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL f4_done_count got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_no_ack();
        logic [10:0] lb;
        bit ok;
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_req(8'hA5);
        dev_xfer(1'b0, lb, ok);
        wait_end(d0, e0);
        total++; if (lb[8:1] !== 8'hA5) begin bad++; $display("FAIL noack_data got=%h want=a5", lb[8:1]); end
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL noack_error_count got=%0d want=1", err_cnt - e0); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL noack_done_count got=%0d want=0", done_cnt - d0); end
        total++; if ({ps2_clk_oe, ps2_dat_oe, tx_busy} !== 3'b000) begin bad++; $display("FAIL noack_release got=%b want=000", {ps2_clk_oe, ps2_dat_oe, tx_busy}); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int d0 = done_cnt;
        int e0 = err_cnt;
        start_req(8'h12);
        while (ps2_clk_oe === 1'b1 && n < 6000) begin @(negedge clk); n++; end
        total++; if (ps2_dat_oe !== 1'b1) begin bad++; $display("FAIL to_rts_dat got=%b want=1", ps2_dat_oe); end
        n = 0;
        while (tx_error !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        total++; if (n !== 200) begin bad++; $display("FAIL to_latency got=%0d want=200", n); end
        total++; if ({ps2_clk_oe, ps2_dat_oe, tx_busy} !== 3'b000) begin bad++; $display("FAIL to_release got=%b want=000", {ps2_clk_oe, ps2_dat_oe, tx_busy}); end
        repeat (5) @(negedge clk);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL to_error_count got=%0d want=1", err_cnt - e0); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL to_done_count got=%0d want=0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] lb;
        bit ok;
        int n = 0;
        int d0, e0;
        start_req(8'h33);
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && n < 6000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        total++; if (ps2_dat_oe !== 1'b1) begin bad++; $display("FAIL mid_bit3_drive got=%b want=1", ps2_dat_oe); end
        @(negedge clk);
        #2 reset_in = 1'b1;
        #1;
        total++; if ({ps2_clk_oe, ps2_dat_oe, tx_busy} !== 3'b000) begin bad++; $display("FAIL mid_async_reset got=%b want=000", {ps2_clk_oe, ps2_dat_oe, tx_busy}); end
        repeat (2) @(negedge clk);
        reset_in = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'h55);
        dev_xfer(1'b1, lb, ok);
        wait_end(d0, e0);
        total++; if (lb[8:1] !== 8'h55) begin bad++; $display("FAIL mid_55_data got=%h want=55", lb[8:1]); end
        total++; if (lb[9] !== 1'b1) begin bad++; $display("FAIL mid_55_parity got=%b want=1", lb[9]); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL mid_55_done got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] lb;
        bit ok;
        int d0 = done_cnt;
        int e0 = err_cnt;
        @(negedge clk);
        tx_data = 8'hA7;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_data = 8'h3B;
        dev_xfer(1'b1, lb, ok);
        wait_end(d0, e0);
        total++; if (lb[8:1] !== 8'hA7) begin bad++; $display("FAIL b2b_first_data got=%h want=a7", lb[8:1]); end
        total++; if (lb[9] !== 1'b0) begin bad++; $display("FAIL b2b_first_parity got=%b want=0", lb[9]); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL b2b_first_done got=%0d want=1", done_cnt - d0); end
        total++; if (last_inh_cyc !== last_done_cyc + 1) begin bad++; $display("FAIL b2b_restart got=%0d want=%0d", last_inh_cyc, last_done_cyc + 1); end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_second got=%b want=1", tx_busy); end
        tx_req = 1'b0;
        dev_xfer(1'b1, lb, ok);
        wait_end(d0 + 1, e0);
        total++; if (lb[8:1] !== 8'h3B) begin bad++; $display("FAIL b2b_second_data got=%h want=3b", lb[8:1]); end
        total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_second_done got=%0d want=2", done_cnt - d0); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b want=0", tx_busy); end
    endtask

    task automatic test_exclusive();
        total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL done_error_overlap got=%b want=0", both_seen); end
    endtask

    initial begin
        reset_in = 1'b1;
        tx_req   = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_send_ed();
        test_inhibit_f4();
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
